// File: rtl/ct_arbiter.sv
// Two-port round-robin read arbiter for the ciphertext ROM.
// Routes each returned byte to its owner through a fixed-length owner pipeline.
module ct_arbiter #(
    parameter int unsigned LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [7:0] addr0,
    input  logic [7:0] addr1,
    output logic [1:0] gnt,
    output logic [7:0] mem_addr,
    input  logic [7:0] mem_rddata,
    output logic [1:0] rvalid,
    output logic [7:0] rdata0,
    output logic [7:0] rdata1
);

    logic           last;
    logic [LAT+1:1] pipe_valid;
    logic [LAT+1:1] pipe_id;

    always_comb begin
        gnt = '0;
        if (!rst) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = last ? 2'b01 : 2'b10;
                default: gnt = '0;
            endcase
        end
    end

    always_comb begin
        mem_addr = '0;
        if (gnt[0])
            mem_addr = addr0;
        else if (gnt[1])
            mem_addr = addr1;
    end

    // Stage k holds the grant issued k cycles ago; stage LAT lines up with mem_rddata.
    always_ff @(posedge clk) begin
        if (rst) begin
            last       <= 1'b1;
            pipe_valid <= '0;
            pipe_id    <= '0;
            rdata0     <= '0;
            rdata1     <= '0;
        end else begin
            if (gnt != 2'b00)
                last <= gnt[1];
            pipe_valid <= {pipe_valid[LAT:1], |gnt};
            pipe_id    <= {pipe_id[LAT:1], gnt[1]};
            if (pipe_valid[LAT]) begin
                if (pipe_id[LAT])
                    rdata1 <= mem_rddata;
                else
                    rdata0 <= mem_rddata;
            end
        end
    end

    assign rvalid = {pipe_valid[LAT+1] & pipe_id[LAT+1],
                     pipe_valid[LAT+1] & ~pipe_id[LAT+1]};

endmodule

// File: doc/ct_arbiter.md
# ct_arbiter

Two-port read arbiter for the ciphertext ROM (`ct_mem`, 256 x 8, synchronous read). It lets two `crack` cores share one ROM read port in the dual-core cracker (key space split between cores). Each cycle it grants at most one requester, issues that address to the ROM, and routes the returned byte back to the owner. A fixed-length owner pipeline covers the ROM read latency.

## Interface
Parameters:
- `LAT`, default 1: ROM read latency in cycles, from address sampled to `mem_rddata` valid. Legal range 1..3.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `req`  in  2  per-requester read request; bit i belongs to requester i.
- `addr0`  in  8  requester 0 ciphertext address.
- `addr1`  in  8  requester 1 ciphertext address.
- `gnt`  out  2  one-hot-or-zero grant, combinational, same cycle as `req`.
- `mem_addr`  out  8  address to `ct_mem.address`.
- `mem_rddata`  in  8  `ct_mem.q`.
- `rvalid`  out  2  one-cycle read-data-valid strobe per requester.
- `rdata0`  out  8  requester 0 read byte, registered.
- `rdata1`  out  8  requester 1 read byte, registered.

## Operation
- Arbitration is round-robin with a 1-bit pointer `last`, the most recently granted requester. Reset value: `last`=1, so requester 0 wins the first tie.
  - `req`=00: `gnt`=00.
  - `req`=01: `gnt`=01.
  - `req`=10: `gnt`=10.
  - `req`=11: grant goes to `~last`.
- `last` updates only in cycles where `gnt`!=0.
- `gnt` is forced to 00 whenever `rst`=1.
- `mem_addr` is `addr0` when `gnt[0]`, `addr1` when `gnt[1]`, else 8'h00.
- Requester contract:
  - Hold `req[i]` and `addr_i` stable until it sees `gnt[i]`.
  - It may drop `req[i]` or change `addr_i` in the cycle after the grant.
- Owner pipeline: a LAT+1 stage shift register of {valid, id}, loaded each cycle from `gnt`. The stage-LAT entry selects which `rdata_i` captures `mem_rddata`.
- Each granted request produces exactly one `rvalid[i]` pulse. Responses return in grant order.
- `rdata_i` holds its last captured value until the next capture for that requester.
- Fairness: under continuous contention (`req`=11), grants alternate strictly. No requester waits more than 1 cycle.
- Reset clears `last`=1, all pipeline valids, `rvalid`=00, `rdata0`=`rdata1`=8'h00. Reset mid-flight drops all outstanding responses; no `rvalid` is emitted for them.
- No FIFOs. Throughput is one read per cycle total, across both requesters.

## Timing
- Grant in cycle t: `mem_addr` is valid in cycle t and sampled by the ROM at the end of t.
- `mem_rddata` is valid in cycle t+LAT and captured into `rdata_i` at the end of t+LAT.
- `rvalid[i]`=1 in cycle t+LAT+1 only, with `rdata_i` valid that cycle. Request-to-data latency is LAT+1 cycles (2 for LAT=1).
- Back-to-back grants to the same requester give back-to-back `rvalid` pulses.
- Reset asserted in cycle r:
  - Outputs take reset values from cycle r+1.
  - `gnt`=00 during cycle r.
  - First grant is possible in the first cycle with `rst`=0.
- Simultaneous grant and reset: reset wins; no response is produced.

## Test plan
Model `ct_mem` with mem[a] = a ^ 8'hA5.
- Reset: `rst`=1 for 2 cycles with `req`=11 -> `gnt`=00, `rvalid`=00, `rdata0`=`rdata1`=8'h00, `mem_addr`=8'h00 throughout.
- Single read: LAT=1, `req`=01 with `addr0`=8'h10 for one cycle t -> `gnt`=01 in t, `mem_addr`=8'h10, `rvalid`=01 in t+2 only, `rdata0`=8'hB5 held afterwards.
- Contention: `req`=11 continuously, `addr0`=8'h01, `addr1`=8'h02, for 6 cycles after reset -> grants 01,10,01,10,01,10. `rvalid` follows 2 cycles later in the same order, with `rdata0`=8'hA4 and `rdata1`=8'hA7.
- Streaming: requester 1 alone for 4 cycles, `addr1`=8'h03..8'h06 -> `gnt`=10 each cycle; `rvalid[1]` high 4 consecutive cycles with `rdata1`=8'hA6,8'hA1,8'hA0,8'hA3.
- Reset mid-flight: grant to requester 0 in cycle t, `rst`=1 in t+1 -> no `rvalid` ever for that grant. After release with `req`=11, the first grant is 01.
- LAT=2 build: repeat the single-read case -> `rvalid[0]` in t+3, `rdata0`=8'hB5; no pulse in t+2.
